// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode types and constants
package fetch_pkg;

  // addi x0, x0, 0 : presented to decode whenever the queue is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular instruction buffer between fetch and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATAOUT_WIDTH = 32,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATAOUT_WIDTH-1:0]   in_instr,
  input  logic [ADDRESS_WIDTH-1:0]   in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [DATAOUT_WIDTH-1:0]   out_instr,
  output logic [ADDRESS_WIDTH-1:0]   out_pc,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAOUT_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;

  // in_ready comes only from cnt, so a full queue refuses a push even while popping
  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

  assign out_instr = out_valid ? instr_mem[rd_ptr] : DATAOUT_WIDTH'(NOP_INSTR);
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; entries are only ever read while cnt covers them
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

endmodule
